// File: rtl/sbus_pkg.sv
// Shared types and widths for the sbus AXI4-Lite responder.
package sbus_pkg;

  localparam int unsigned SBUS_DATA_W = 32;
  localparam int unsigned SBUS_STRB_W = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/sbus_wait_ctr.sv
// Wait-state counter: loads a value, counts down to zero, flags zero.
module sbus_wait_ctr #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/sbus_axil_responder.sv
// AXI4-Lite subordinate backing a byte-strobed scratch RAM on the system bus.
// Optional response wait states are enabled by defining SBUS_RSP_WAIT_EN.
module sbus_axil_responder
  import sbus_pkg::*;
#(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h2000_0000),
  parameter int unsigned       WAIT   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_sbus_aw_valid,
  output logic                   io_sbus_aw_ready,
  input  logic [ADDR_W-1:0]      io_sbus_aw_bits_addr,
  input  logic                   io_sbus_w_valid,
  output logic                   io_sbus_w_ready,
  input  logic [SBUS_DATA_W-1:0] io_sbus_w_bits_data,
  input  logic [SBUS_STRB_W-1:0] io_sbus_w_bits_strb,
  output logic                   io_sbus_b_valid,
  input  logic                   io_sbus_b_ready,
  output logic [1:0]             io_sbus_b_bits_resp,
  input  logic                   io_sbus_ar_valid,
  output logic                   io_sbus_ar_ready,
  input  logic [ADDR_W-1:0]      io_sbus_ar_bits_addr,
  output logic                   io_sbus_r_valid,
  input  logic                   io_sbus_r_ready,
  output logic [SBUS_DATA_W-1:0] io_sbus_r_bits_data,
  output logic [1:0]             io_sbus_r_bits_resp
);

  localparam int unsigned       IDX_W  = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned       WAIT_W = (WAIT < 2) ? 1 : $clog2(WAIT + 1);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(4 * DEPTH);

  logic [SBUS_DATA_W-1:0] mem [DEPTH];

  wstate_t                r_wstate, w_wnxt;
  logic [ADDR_W-1:0]      r_aw_addr;
  logic [SBUS_DATA_W-1:0] r_w_data;
  logic [SBUS_STRB_W-1:0] r_w_strb;
  logic                   r_aw_ready, r_w_ready, r_b_hold;
  resp_t                  r_b_resp;
  logic                   w_aw_ready_nxt, w_w_ready_nxt, w_b_hold_nxt, w_commit;

  rstate_t                r_rstate, w_rnxt;
  logic                   r_ar_ready, r_r_hold;
  logic [SBUS_DATA_W-1:0] r_r_data;
  resp_t                  r_r_resp;
  logic                   w_ar_ready_nxt, w_r_hold_nxt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_b_zero, w_r_zero, w_b_valid, w_r_valid;

  assign w_aw_hs = io_sbus_aw_valid & r_aw_ready;
  assign w_w_hs  = io_sbus_w_valid & r_w_ready;
  assign w_b_hs  = w_b_valid & io_sbus_b_ready;
  assign w_ar_hs = io_sbus_ar_valid & r_ar_ready;
  assign w_r_hs  = w_r_valid & io_sbus_r_ready;

  // Commit source: whichever half arrived earlier is taken from its holding register
  logic [ADDR_W-1:0]      w_wr_addr, w_wr_off, w_rd_off;
  logic [SBUS_DATA_W-1:0] w_wr_data;
  logic [SBUS_STRB_W-1:0] w_wr_strb;
  logic [IDX_W-1:0]       w_wr_idx, w_rd_idx;
  logic                   w_wr_ok, w_rd_ok;

  assign w_wr_addr = (r_wstate == W_HAVE_AW) ? r_aw_addr : io_sbus_aw_bits_addr;
  assign w_wr_data = (r_wstate == W_HAVE_W) ? r_w_data : io_sbus_w_bits_data;
  assign w_wr_strb = (r_wstate == W_HAVE_W) ? r_w_strb : io_sbus_w_bits_strb;

  // Range decode; the subtraction wraps below BASE, hence the explicit lower bound
  assign w_wr_off = w_wr_addr - BASE;
  assign w_wr_ok  = (w_wr_addr >= BASE) && (w_wr_off < SPAN);
  assign w_wr_idx = w_wr_off[IDX_W+1:2];
  assign w_rd_off = io_sbus_ar_bits_addr - BASE;
  assign w_rd_ok  = (io_sbus_ar_bits_addr >= BASE) && (w_rd_off < SPAN);
  assign w_rd_idx = w_rd_off[IDX_W+1:2];

  always_comb begin
    w_wnxt   = r_wstate;
    w_commit = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wnxt   = W_RESP;
          w_commit = 1'b1;
        end else if (w_aw_hs) begin
          w_wnxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_wnxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_w_hs) begin
          w_wnxt   = W_RESP;
          w_commit = 1'b1;
        end
      end
      W_HAVE_W: begin
        if (w_aw_hs) begin
          w_wnxt   = W_RESP;
          w_commit = 1'b1;
        end
      end
      W_RESP: begin
        if (w_b_hs) w_wnxt = W_IDLE;
      end
      default: w_wnxt = W_IDLE;
    endcase
    w_aw_ready_nxt = (w_wnxt == W_IDLE) || (w_wnxt == W_HAVE_W);
    w_w_ready_nxt  = (w_wnxt == W_IDLE) || (w_wnxt == W_HAVE_AW);
    w_b_hold_nxt   = (w_wnxt == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wstate   <= W_IDLE;
      r_aw_ready <= 1'b1;
      r_w_ready  <= 1'b1;
      r_b_hold   <= 1'b0;
      r_b_resp   <= RESP_OKAY;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
    end else begin
      r_wstate   <= w_wnxt;
      r_aw_ready <= w_aw_ready_nxt;
      r_w_ready  <= w_w_ready_nxt;
      r_b_hold   <= w_b_hold_nxt;
      if (w_aw_hs) r_aw_addr <= io_sbus_aw_bits_addr;
      if (w_w_hs) begin
        r_w_data <= io_sbus_w_bits_data;
        r_w_strb <= io_sbus_w_bits_strb;
      end
      if (w_commit) r_b_resp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // RAM is never cleared; writes are blocked while reset is asserted
  always_ff @(posedge clock) begin
    if (reset && w_commit && w_wr_ok) begin
      for (int i = 0; i < int'(SBUS_STRB_W); i++) begin
        if (w_wr_strb[i]) mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rnxt = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnxt = R_DATA;
      R_DATA:  if (w_r_hs) w_rnxt = R_IDLE;
      default: w_rnxt = R_IDLE;
    endcase
    w_ar_ready_nxt = (w_rnxt == R_IDLE);
    w_r_hold_nxt   = (w_rnxt == R_DATA);
  end

  // Read samples the array with the pre-edge contents, so a same-edge write is not visible
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rstate   <= R_IDLE;
      r_ar_ready <= 1'b1;
      r_r_hold   <= 1'b0;
      r_r_data   <= '0;
      r_r_resp   <= RESP_OKAY;
    end else begin
      r_rstate   <= w_rnxt;
      r_ar_ready <= w_ar_ready_nxt;
      r_r_hold   <= w_r_hold_nxt;
      if (w_ar_hs) begin
        r_r_data <= w_rd_ok ? mem[w_rd_idx] : '0;
        r_r_resp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

`ifdef SBUS_RSP_WAIT_EN
  sbus_wait_ctr #(.CNT_W(WAIT_W)) u_b_wait (
    .clock      (clock),
    .reset      (reset),
    .i_load     ((w_wnxt == W_RESP) && (r_wstate != W_RESP)),
    .i_load_val (WAIT_W'(WAIT)),
    .i_dec      (r_wstate == W_RESP),
    .o_zero_c   (w_b_zero)
  );

  sbus_wait_ctr #(.CNT_W(WAIT_W)) u_r_wait (
    .clock      (clock),
    .reset      (reset),
    .i_load     ((w_rnxt == R_DATA) && (r_rstate != R_DATA)),
    .i_load_val (WAIT_W'(WAIT)),
    .i_dec      (r_rstate == R_DATA),
    .o_zero_c   (w_r_zero)
  );
`else
  logic w_unused_wait_cfg;
  assign w_unused_wait_cfg = (WAIT_W != 0);
  assign w_b_zero = 1'b1;
  assign w_r_zero = 1'b1;
`endif

  assign w_b_valid = r_b_hold & w_b_zero;
  assign w_r_valid = r_r_hold & w_r_zero;

  assign io_sbus_aw_ready    = r_aw_ready;
  assign io_sbus_w_ready     = r_w_ready;
  assign io_sbus_b_valid     = w_b_valid;
  assign io_sbus_b_bits_resp = r_b_resp;
  assign io_sbus_ar_ready    = r_ar_ready;
  assign io_sbus_r_valid     = w_r_valid;
  assign io_sbus_r_bits_data = r_r_data;
  assign io_sbus_r_bits_resp = r_r_resp;

endmodule

// File: tb/tb_sbus_axil_responder.sv
// Directed self-checking bench for sbus_axil_responder (default build, no wait states).
module tb_sbus_axil_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
  logic [3:0]  w_strb = '0;
  logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;

  int checks = 0;
  int failures = 0;

  sbus_axil_responder dut (
    .clock                (clock),
    .reset                (reset),
    .io_sbus_aw_valid     (aw_valid),
    .io_sbus_aw_ready     (aw_ready),
    .io_sbus_aw_bits_addr (aw_addr),
    .io_sbus_w_valid      (w_valid),
    .io_sbus_w_ready      (w_ready),
    .io_sbus_w_bits_data  (w_data),
    .io_sbus_w_bits_strb  (w_strb),
    .io_sbus_b_valid      (b_valid),
    .io_sbus_b_ready      (b_ready),
    .io_sbus_b_bits_resp  (b_resp),
    .io_sbus_ar_valid     (ar_valid),
    .io_sbus_ar_ready     (ar_ready),
    .io_sbus_ar_bits_addr (ar_addr),
    .io_sbus_r_valid      (r_valid),
    .io_sbus_r_ready      (r_ready),
    .io_sbus_r_bits_data  (r_data),
    .io_sbus_r_bits_resp  (r_resp)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit to);
    aw_valid = 1'b1; aw_addr = a; w_valid = 1'b1; w_data = d; w_strb = s;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (b_valid) begin to = 1'b0; break; end
      tick();
    end
    resp = b_resp;
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit to);
    ar_valid = 1'b1; ar_addr = a;
    tick();
    ar_valid = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (r_valid) begin to = 1'b0; break; end
      tick();
    end
    d = r_data; resp = r_resp;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
      failures++; $display("FAIL reset_ready: got %b expected 111", {aw_ready, w_ready, ar_ready});
    end
    checks++;
    if ({b_valid, r_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_valid: got %b expected 00", {b_valid, r_valid});
    end
    checks++;
    if ({b_resp, r_resp, r_data} !== 36'h0) begin
      failures++; $display("FAIL reset_resp_data: got %h expected 0", {b_resp, r_resp, r_data});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] rs; bit to;
    aw_valid = 1'b1; aw_addr = 32'h2000_0010; w_valid = 1'b1; w_data = 32'hDEAD_BEEF; w_strb = 4'hF;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    checks++;
    if ({b_valid, b_resp, aw_ready, w_ready} !== 5'b1_00_0_0) begin
      failures++; $display("FAIL basic_b_next_cycle: got %b expected 10000", {b_valid, b_resp, aw_ready, w_ready});
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    checks++;
    if ({b_valid, aw_ready, w_ready} !== 3'b011) begin
      failures++; $display("FAIL basic_b_release: got %b expected 011", {b_valid, aw_ready, w_ready});
    end
    ar_valid = 1'b1; ar_addr = 32'h2000_0010;
    tick();
    ar_valid = 1'b0;
    checks++;
    if ({r_valid, r_resp, ar_ready} !== 4'b1_00_0 || r_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL basic_read: got v/resp/rdy %b data %h expected 1000 deadbeef",
                           {r_valid, r_resp, ar_ready}, r_data);
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    checks++;
    if ({r_valid, ar_ready} !== 2'b01) begin
      failures++; $display("FAIL basic_r_release: got %b expected 01", {r_valid, ar_ready});
    end
    bus_read(32'h2000_0010, d, rs, to);
    checks++;
    if (to || d !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL basic_reread: got %h to=%0d expected deadbeef", d, to);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] rs; bit to;
    bus_write(32'h2000_0020, 32'h1122_3344, 4'hF, rs, to);
    bus_write(32'h2000_0020, 32'hAABB_CCDD, 4'b0101, rs, to);
    checks++;
    if (to || rs !== 2'b00) begin
      failures++; $display("FAIL strobe_bresp: got %b to=%0d expected 00", rs, to);
    end
    bus_read(32'h2000_0020, d, rs, to);
    checks++;
    if (to || d !== 32'h11BB_33DD || rs !== 2'b00) begin
      failures++; $display("FAIL strobe_read: got %h resp %b expected 11bb33dd 00", d, rs);
    end
    checks++;
    if (dut.mem[8] !== 32'h11BB_33DD) begin
      failures++; $display("FAIL strobe_backdoor: got %h expected 11bb33dd", dut.mem[8]);
    end
  endtask

  task automatic test_w_first();
    logic [31:0] d; logic [1:0] rs; bit to;
    w_valid = 1'b1; w_data = 32'hCAFE_F00D; w_strb = 4'hF;
    tick();
    w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({w_ready, aw_ready, b_valid} !== 3'b010) begin
        failures++; $display("FAIL wfirst_wait%0d: got %b expected 010", i, {w_ready, aw_ready, b_valid});
      end
      tick();
    end
    aw_valid = 1'b1; aw_addr = 32'h2000_0030;
    tick();
    aw_valid = 1'b0;
    checks++;
    if ({b_valid, b_resp} !== 3'b1_00) begin
      failures++; $display("FAIL wfirst_b: got %b expected 100", {b_valid, b_resp});
    end
    b_ready = 1'b1;
    tick();
    tick();
    b_ready = 1'b0;
    checks++;
    if (b_valid !== 1'b0) begin
      failures++; $display("FAIL wfirst_single_b: got %b expected 0", b_valid);
    end
    bus_read(32'h2000_0030, d, rs, to);
    checks++;
    if (to || d !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL wfirst_read: got %h expected cafef00d", d);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] rs; bit to;
    bus_write(32'h2000_0FFC, 32'h5A5A_5A5A, 4'hF, rs, to);
    bus_write(32'h1FFF_FFFC, 32'h1234_5678, 4'hF, rs, to);
    checks++;
    if (to || rs !== 2'b10) begin
      failures++; $display("FAIL slverr_low_write: got %b to=%0d expected 10", rs, to);
    end
    bus_read(32'h2000_0FFC, d, rs, to);
    checks++;
    if (to || d !== 32'h5A5A_5A5A || rs !== 2'b00) begin
      failures++; $display("FAIL slverr_no_change: got %h resp %b expected 5a5a5a5a 00", d, rs);
    end
    bus_read(32'h2000_1000, d, rs, to);
    checks++;
    if (to || d !== 32'h0 || rs !== 2'b10) begin
      failures++; $display("FAIL slverr_high_read: got %h resp %b expected 0 10", d, rs);
    end
    bus_write(32'h2000_1000, 32'h9999_9999, 4'hF, rs, to);
    checks++;
    if (to || rs !== 2'b10) begin
      failures++; $display("FAIL slverr_high_write: got %b expected 10", rs);
    end
  endtask

  task automatic test_backpressure();
    aw_valid = 1'b1; aw_addr = 32'h2000_0060; w_valid = 1'b1; w_data = 32'h1357_9BDF; w_strb = 4'hF;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({b_valid, b_resp, aw_ready, w_ready} !== 5'b1_00_0_0) begin
        failures++; $display("FAIL bp_b_hold%0d: got %b expected 10000", i, {b_valid, b_resp, aw_ready, w_ready});
      end
      tick();
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    checks++;
    if ({b_valid, aw_ready, w_ready} !== 3'b011) begin
      failures++; $display("FAIL bp_b_idle: got %b expected 011", {b_valid, aw_ready, w_ready});
    end
    ar_valid = 1'b1; ar_addr = 32'h2000_0060;
    tick();
    ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({r_valid, r_resp, ar_ready} !== 4'b1_00_0 || r_data !== 32'h1357_9BDF) begin
        failures++; $display("FAIL bp_r_hold%0d: got %b data %h expected 1000 13579bdf",
                             i, {r_valid, r_resp, ar_ready}, r_data);
      end
      tick();
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    checks++;
    if ({r_valid, ar_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_r_idle: got %b expected 01", {r_valid, ar_ready});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] rs; bit to;
    bus_write(32'h2000_0040, 32'h0102_0304, 4'hF, rs, to);
    aw_valid = 1'b1; aw_addr = 32'h2000_0040;
    tick();
    aw_valid = 1'b0;
    checks++;
    if ({aw_ready, w_ready} !== 2'b01) begin
      failures++; $display("FAIL rstmid_have_aw: got %b expected 01", {aw_ready, w_ready});
    end
    reset = 1'b0;
    w_valid = 1'b1; w_data = 32'hFFFF_FFFF; w_strb = 4'hF;
    tick();
    w_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({aw_ready, w_ready, ar_ready, b_valid} !== 4'b1110) begin
      failures++; $display("FAIL rstmid_idle: got %b expected 1110", {aw_ready, w_ready, ar_ready, b_valid});
    end
    tick(); tick();
    checks++;
    if (b_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_b: got %b expected 0", b_valid);
    end
    bus_read(32'h2000_0040, d, rs, to);
    checks++;
    if (to || d !== 32'h0102_0304) begin
      failures++; $display("FAIL rstmid_ram: got %h expected 01020304", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] rs; bit to;
    bus_write(32'h2000_0050, 32'h0BAD_F00D, 4'hF, rs, to);
    aw_valid = 1'b1; aw_addr = 32'h2000_0050; w_valid = 1'b1; w_data = 32'h600D_F00D; w_strb = 4'hF;
    ar_valid = 1'b1; ar_addr = 32'h2000_0050;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    checks++;
    if ({b_valid, r_valid} !== 2'b11 || r_data !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL rbw_same_cycle: got v %b data %h expected 11 0badf00d", {b_valid, r_valid}, r_data);
    end
    b_ready = 1'b1; r_ready = 1'b1;
    tick();
    b_ready = 1'b0; r_ready = 1'b0;
    bus_read(32'h2000_0050, d, rs, to);
    checks++;
    if (to || d !== 32'h600D_F00D) begin
      failures++; $display("FAIL rbw_after: got %h expected 600df00d", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_w_first();
    test_slverr();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
